udc_btn_cond: RTL
=================

Name: udc_btn_cond

Overview:
- Push-button conditioner that sits directly upstream of the up/down counter (UDC).
- Turns two raw, bouncing board buttons into clean controls for the counter:
  - a single-cycle count-step pulse, with optional auto-repeat while the button is held;
  - a registered direction level (`updown`) that toggles on each press of the direction button.
- Every output is registered and synchronous to the same clock as the counter.

Parameters:
- DEB_CYCLES, 16: number of consecutive clock edges a synchronized input must disagree with its debounced level before that level flips (minimum 2).
- REPEAT_DELAY, 64: clock cycles from the first step pulse to the first auto-repeat pulse (minimum 2).
- REPEAT_RATE, 16: clock cycles between successive auto-repeat pulses (minimum 2).

Ports:
- clock  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clock).
- btn_step  input  1  raw step button, asynchronous, active-high.
- btn_dir  input  1  raw direction button, asynchronous, active-high.
- repeat_en  input  1  1 = auto-repeat enabled while btn_step is held. Synchronous; sampled every cycle.
- step_pulse  output  1  one-cycle count enable to the counter.
- updown  output  1  count direction to the counter: 1 = up, 0 = down.
- step_held  output  1  debounced level of btn_step.

Behaviour:
- Reset (reset = 0 at a rising edge):
  - Synchronizers, debounce counters, debounced levels, hold timer and FSM all clear; FSM goes to IDLE.
  - step_pulse = 0, step_held = 0, updown = 1.
- Synchronizer:
  - Each button passes through 2 flops (q1, q2); q2 is the synchronized level.
- Debounce (one independent instance per button):
  - A counter, width $clog2(DEB_CYCLES)+1, increments on each edge where q2 != debounced level.
  - The counter clears on any edge where q2 == debounced level.
  - On the DEB_CYCLES-th consecutive differing edge, the debounced level takes q2 and the counter clears.
  - Latency: raw input high before edge k and held stable → debounced level changes at edge k+1+DEB_CYCLES.
  - A glitch shorter than DEB_CYCLES cycles has no effect.
- Direction:
  - On the edge where the btn_dir debounced level rises 0→1, updown inverts.
  - A release does nothing; holding the button does nothing further.
- Step FSM. States: IDLE, HELD, REPEAT.
  - IDLE: on the btn_step debounced rise, step_pulse = 1 for exactly one cycle (registered on the same edge as the rise), hold timer ← 0, go to HELD.
  - HELD:
    - hold timer increments each cycle;
    - when it reaches REPEAT_DELAY-1 with repeat_en = 1: pulse, timer ← 0, go to REPEAT;
    - if repeat_en = 0, the timer saturates and no pulse is generated.
  - REPEAT: on reaching REPEAT_RATE-1 with repeat_en = 1, pulse and timer ← 0.
  - repeat_en dropping in REPEAT: go to HELD with the timer saturated. No further pulses until release and a fresh press.
  - Debounced fall in any state: go to IDLE, no pulse, timer cleared. A fall takes priority over a pending repeat pulse on the same edge.
- Pulse spacing: step_pulse is never high on two consecutive cycles.
- Simultaneous events: a direction toggle and a step pulse registered on the same edge are both applied. The counter sees the new updown together with that pulse.
- Reset mid-hold:
  - All state clears.
  - If the button is still held after reset releases, it is treated as a fresh press: one pulse after debounce latency, then the repeat sequence.
- step_held follows the btn_step debounced level (registered).

Test Plan:
Bench parameters for every scenario: DEB_CYCLES = 4, REPEAT_DELAY = 20, REPEAT_RATE = 8; clock period 10 ns.
1. Reset held low 3 cycles, then released → step_pulse = 0, step_held = 0, updown = 1.
2. Clean press, btn_step high from edge 0, repeat_en = 0 → step_pulse high only in the cycle after edge 5; no further pulse over 100 cycles; step_held = 1 from edge 5.
3. Bounce: btn_step toggled every 2 cycles for 20 cycles, then held high → zero pulses during the bounce; exactly one pulse 5 edges after the hold starts.
4. Auto-repeat, repeat_en = 1, btn_step held 60 cycles → pulses at cycle offsets 0, 20, 28, 36, 44, 52 relative to the first pulse; none after the debounced release.
5. Direction: btn_dir pressed and released 3 times, each press clean for 10 cycles → updown goes 1→0→1→0, each change 5 edges after the press. btn_dir pressed on the same edge as btn_step → step_pulse and the updown change register on the same edge.
6. Reset mid-hold: in REPEAT, reset asserted 2 cycles while btn_step stays high → outputs clear; after release, first pulse 5 edges later, then a repeat 20 cycles after it.

Source files
------------

// File: rtl/udc_btn_cond.sv
// udc_btn_cond: push-button conditioner for the up/down counter.
// Turns two raw, bouncing buttons into a one-cycle count-step pulse
// (with optional auto-repeat), a toggling direction level, and the
// debounced step-button level. All outputs are registered on clock.

`timescale 1ns/1ps

// Two-flop synchronizer followed by a consecutive-disagreement debouncer.
// level      : registered debounced level
// level_next : value level takes on the coming edge, so edge detectors
//              downstream can register their reaction on that same edge
module udc_btn_cond_deb #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic level_next
);

  localparam int CW = $clog2(DEB_CYCLES) + 1;

  logic          q1_r;
  logic          q2_r;
  logic          level_r;
  logic          level_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clock) begin
    if (!reset) begin
      q1_r <= 1'b0;
      q2_r <= 1'b0;
    end else begin
      q1_r <= raw;
      q2_r <= q1_r;
    end
  end

  // Count consecutive edges where the synchronized input disagrees with
  // the debounced level; flip the level on the DEB_CYCLES-th one.
  always_comb begin
    cnt_s   = {CW{1'b0}};
    level_s = level_r;
    if (q2_r != level_r) begin
      if (cnt_r == CW'(DEB_CYCLES - 1)) begin
        level_s = q2_r;
        cnt_s   = {CW{1'b0}};
      end else begin
        cnt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_s = {CW{1'b0}};
    end
  end

  // Debounce counter and level registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_r   <= {CW{1'b0}};
      level_r <= 1'b0;
    end else begin
      cnt_r   <= cnt_s;
      level_r <= level_s;
    end
  end

  assign level      = level_r;
  assign level_next = level_s;

endmodule

module udc_btn_cond #(
  parameter int DEB_CYCLES   = 16,
  parameter int REPEAT_DELAY = 64,
  parameter int REPEAT_RATE  = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_step,
  input  logic btn_dir,
  input  logic repeat_en,
  output logic step_pulse,
  output logic updown,
  output logic step_held
);

  // Timer needs to hold REPEAT_DELAY itself: that value is the
  // "saturated, repeat locked out" marker, one past the firing point.
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW      = $clog2(TMR_MAX + 1);

  localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LAST = TW'(REPEAT_RATE - 1);
  localparam logic [TW-1:0] TMR_SAT  = TW'(REPEAT_DELAY);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  logic          step_lvl_s;
  logic          step_nxt_s;
  logic          dir_lvl_s;
  logic          dir_nxt_s;
  logic          step_rise_s;
  logic          step_fall_s;
  logic          dir_rise_s;

  state_t        state_r;
  state_t        state_s;
  logic [TW-1:0] tmr_r;
  logic [TW-1:0] tmr_s;
  logic          pulse_s;
  logic          step_pulse_r;
  logic          updown_r;
  logic          step_held_r;

  udc_btn_cond_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .clock      (clock),
    .reset      (reset),
    .raw        (btn_step),
    .level      (step_lvl_s),
    .level_next (step_nxt_s)
  );

  udc_btn_cond_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dir (
    .clock      (clock),
    .reset      (reset),
    .raw        (btn_dir),
    .level      (dir_lvl_s),
    .level_next (dir_nxt_s)
  );

  // Edges of the debounced levels, seen on the edge they are registered.
  assign step_rise_s = step_nxt_s & ~step_lvl_s;
  assign step_fall_s = ~step_nxt_s & step_lvl_s;
  assign dir_rise_s  = dir_nxt_s & ~dir_lvl_s;

  // Step FSM: next state, hold timer and pulse request.
  always_comb begin
    state_s = state_r;
    tmr_s   = tmr_r;
    pulse_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tmr_s = {TW{1'b0}};
        if (step_rise_s) begin
          pulse_s = 1'b1;
          state_s = ST_HELD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (step_fall_s) begin
          state_s = ST_IDLE;
          tmr_s   = {TW{1'b0}};
        end else if (tmr_r == DLY_LAST) begin
          if (repeat_en) begin
            pulse_s = 1'b1;
            tmr_s   = {TW{1'b0}};
            state_s = ST_REPEAT;
          end else begin
            tmr_s = TMR_SAT;
          end
        end else if (tmr_r >= TMR_SAT) begin
          tmr_s = TMR_SAT;
        end else begin
          tmr_s = tmr_r + TMR_ONE;
        end
      end
      ST_REPEAT: begin
        if (step_fall_s) begin
          state_s = ST_IDLE;
          tmr_s   = {TW{1'b0}};
        end else if (!repeat_en) begin
          state_s = ST_HELD;
          tmr_s   = TMR_SAT;
        end else if (tmr_r == RATE_LAST) begin
          pulse_s = 1'b1;
          tmr_s   = {TW{1'b0}};
        end else begin
          tmr_s = tmr_r + TMR_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        tmr_s   = {TW{1'b0}};
      end
    endcase
  end

  // Step FSM state, hold timer and registered step pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      tmr_r        <= {TW{1'b0}};
      step_pulse_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      tmr_r        <= tmr_s;
      step_pulse_r <= pulse_s;
    end
  end

  // Direction toggles on each debounced press; step_held mirrors the level.
  always_ff @(posedge clock) begin
    if (!reset) begin
      updown_r    <= 1'b1;
      step_held_r <= 1'b0;
    end else begin
      updown_r    <= dir_rise_s ? ~updown_r : updown_r;
      step_held_r <= step_nxt_s;
    end
  end

  assign step_pulse = step_pulse_r;
  assign updown     = updown_r;
  assign step_held  = step_held_r;

endmodule
